// File: rtl/rr_arb16_pkg.sv
// rtl/rr_arb16_pkg.sv - shared sizes, FSM state type and round-robin search for rr_arb16
package rr_arb16_pkg;

  localparam int NREQ        = 16;
  localparam int IDW         = 4;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // First set request at or above ptr, wrapping from NREQ-1 back to 0.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                             input logic [IDW-1:0]  ptr);
    logic [IDW-1:0] w_idx;
    logic [IDW-1:0] w_sel;
    logic           w_found;
    w_sel   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = ptr + IDW'(k);
      if (!w_found && req[w_idx]) begin
        w_sel   = w_idx;
        w_found = 1'b1;
      end
    end
    return w_sel;
  endfunction

endpackage

// File: rtl/rr_arb16_onehot_n_dec.sv
// rtl/rr_arb16_onehot_n_dec.sv - 4-to-16 active-low one-hot decoder with active-low enable
module onehot_n_dec
  import rr_arb16_pkg::*;
(
  input  logic [IDW-1:0]  i_sel,
  input  logic            i_en_n,
  output logic [NREQ-1:0] o_dec_n
);

  always_comb begin
    o_dec_n = '1;
    if (!i_en_n) o_dec_n[i_sel] = 1'b0;
  end

endmodule

// File: rtl/rr_arb16.sv
// rtl/rr_arb16.sv - 16-way round-robin lock-until-release arbiter
// Optional hold timeout compiled in with `define RR_ARB16_TIMEOUT_EN (adds timeout_o).
module rr_arb16
  import rr_arb16_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt_n,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_valid
`ifdef RR_ARB16_TIMEOUT_EN
  ,
  output logic            timeout_o
`endif
);

  state_t         r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_gnt_id;
  logic [IDW-1:0] w_pick;
  logic           w_start;
  logic           w_release;
  logic           w_dec_en_n;

  assign w_pick  = rr_pick(req, r_ptr);
  assign w_start = (r_state == IDLE) && !en_n && (req != '0);

`ifdef RR_ARB16_TIMEOUT_EN
  logic [4:0] r_cnt;
  logic       r_timeout;
  logic       w_expire;

  assign w_expire  = (r_cnt == 5'(TIMEOUT));
  assign w_release = w_expire || !req[r_gnt_id];

  // r_cnt is 1 in the first grant cycle, so TIMEOUT grant cycles elapse before w_expire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= (r_state == GRANT) && w_expire;
      if (r_state == IDLE)
        r_cnt <= w_start ? 5'd1 : 5'd0;
      else if (w_release)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 5'd1;
    end
  end

  assign timeout_o = r_timeout;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_release        = !req[r_gnt_id];
`endif

  // Leaving GRANT always lands in IDLE, which gives the mandatory turnaround cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_gnt_id <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state  <= GRANT;
            r_gnt_id <= w_pick;
            r_ptr    <= w_pick + 4'd1;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_state  <= IDLE;
            r_gnt_id <= '0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_gnt_id <= '0;
        end
      endcase
    end
  end

  assign gnt_valid  = (r_state == GRANT);
  assign gnt_id     = r_gnt_id;
  assign w_dec_en_n = ~gnt_valid;

  onehot_n_dec u_dec (
    .i_sel   (r_gnt_id),
    .i_en_n  (w_dec_en_n),
    .o_dec_n (gnt_n)
  );

endmodule

// File: tb/tb_rr_arb16.sv
// tb/tb_rr_arb16.sv - scoreboard bench for rr_arb16 against a behavioural arbitration model
module tb_rr_arb16;

  localparam int TMO = 16;
`ifdef RR_ARB16_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        en_n;
  logic [15:0] req;
  logic [15:0] gnt_n;
  logic [3:0]  gnt_id;
  logic        gnt_valid;
  logic        timeout_o;

  always #5 clk = ~clk;

  rr_arb16 #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .en_n      (en_n),
    .req       (req),
    .gnt_n     (gnt_n),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
`ifdef RR_ARB16_TIMEOUT_EN
    ,
    .timeout_o (timeout_o)
`endif
  );

`ifndef RR_ARB16_TIMEOUT_EN
  assign timeout_o = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] gn;
    logic [3:0]  id;
    logic        v;
    logic        to;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state: owner index or -1, next search start, grant cycles so far.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  bit m_to    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.gn = 16'hFFFF;
    e.id = 4'd0;
    e.v  = 1'b0;
    e.to = m_to;
    if (m_owner >= 0) begin
      e.gn[m_owner] = 1'b0;
      e.id = 4'(m_owner);
      e.v  = 1'b1;
    end
    return e;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_step();
    m_to = 1'b0;
    if (reset) begin
      model_reset();
    end else if (m_owner < 0) begin
      if (!en_n && req != 16'h0) begin
        for (int k = 0; k < 16; k++) begin
          if (req[(m_ptr + k) % 16]) begin
            m_owner = (m_ptr + k) % 16;
            m_ptr   = (m_owner + 1) % 16;
            m_cnt   = 1;
            break;
          end
        end
      end
    end else if (TO_EN && m_cnt == TMO) begin
      m_owner = -1;
      m_cnt   = 0;
      m_to    = 1'b1;
    end else if (!req[m_owner]) begin
      m_owner = -1;
      m_cnt   = 0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    q.push_back(model_out());
    #1;
  endtask

  // Called just after a tick: asynchronous assert, held over one edge, released after it.
  task automatic reset_pulse();
    reset = 1'b1;
    q.delete();
    model_reset();
    q.push_back(model_out());
    #1;
    chk("async_rst_valid", 32'(gnt_valid), 32'd0);
    chk("async_rst_gnt_n", 32'(gnt_n), 32'hFFFF);
    chk("async_rst_gnt_id", 32'(gnt_id), 32'd0);
    tick();
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("gnt_n", 32'(gnt_n), 32'(e.gn));
      chk("gnt_id", 32'(gnt_id), 32'(e.id));
      chk("gnt_valid", 32'(gnt_valid), 32'(e.v));
      if (TO_EN) chk("timeout_o", 32'(timeout_o), 32'(e.to));
    end
  end

  initial begin
    logic [15:0] r;
    reset = 1'b1;
    en_n  = 1'b1;
    req   = 16'h0;
    tick();
    tick();
    reset = 1'b0;

    en_n = 1'b0;
    req  = 16'h0001;
    tick(); tick();
    req = 16'h0;
    tick(); tick();

    reset_pulse();
    repeat (60) begin
      if (m_owner >= 0 && m_cnt >= 2) req = ~(16'h0001 << m_owner);
      else req = 16'hFFFF;
      tick();
    end
    req = 16'h0;
    tick(); tick(); tick();

    req = 16'h4000;
    tick(); tick();
    req = 16'h0;
    tick(); tick();
    req = 16'h8001;
    tick(); tick();
    req = 16'h0001;
    tick(); tick(); tick(); tick();
    req = 16'h0;
    tick(); tick();

    req = 16'h0008;
    tick();
    en_n = 1'b1;
    tick(); tick(); tick();
    req = 16'h0001;
    repeat (4) tick();
    en_n = 1'b0;
    tick(); tick();
    req = 16'h0;
    tick(); tick();

    req = 16'h0080;
    tick(); tick(); tick();
    reset_pulse();
    req = 16'h0081;
    tick(); tick(); tick();
    req = 16'h0;
    tick(); tick();

    if (TO_EN) begin
      reset_pulse();
      req = 16'h0021;
      repeat (45) tick();
      req = 16'h0;
      tick(); tick();
    end

    repeat (1500) begin
      if ($urandom_range(149) == 0) begin
        reset_pulse();
      end else begin
        en_n = ($urandom_range(3) == 0);
        r = 16'($urandom) & 16'($urandom);
        if (m_owner >= 0 && $urandom_range(4) != 0) r[m_owner] = 1'b1;
        req = r;
        tick();
      end
    end

    req = 16'h0;
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arb16.md
RR_ARB16 -- requirements
Module: rr_arb16

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, giving the maximum consecutive grant cycles (used only under REQ-026).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 en_n  input  1  active-low arbitration enable; high SHALL block new grants.
REQ-005 req  input  16  active-high request per requester; requester holds req high for as long as it owns the resource.
REQ-006 gnt_n  output  16  active-low one-hot grant; all ones SHALL mean no grant.
REQ-007 gnt_id  output  4  index of current owner; SHALL be 0 when gnt_valid is low.
REQ-008 gnt_valid  output  1  high while a grant is held.

Function
REQ-009 The FSM SHALL have states IDLE and GRANT.
REQ-010 IDLE->GRANT SHALL occur when en_n=0 and req!=0; the owner SHALL be the first set req bit searching upward from pointer ptr, wrapping 15->0.
REQ-011 Grant latency SHALL be one cycle: req sampled in IDLE at edge n, so gnt_n/gnt_id/gnt_valid valid after edge n.
REQ-012 In GRANT the owner SHALL be locked; changes to other req bits SHALL have no effect.
REQ-013 GRANT->IDLE SHALL occur on the edge where req[owner]=0; the grant SHALL drop after that edge.
REQ-014 After every release the block SHALL spend at least one cycle in IDLE (turnaround) before the next grant.
REQ-015 On each grant ptr SHALL become (owner+1) mod 16; 15 SHALL wrap to 0.
REQ-016 en_n going high during GRANT SHALL NOT revoke the current grant; it SHALL only block the next IDLE->GRANT.
REQ-017 Exactly one gnt_n bit SHALL be low in GRANT, and gnt_n SHALL be 16'hFFFF in IDLE.
REQ-018 gnt_n SHALL be the active-low decode of gnt_id qualified by gnt_valid.
REQ-019 A requester that drops and reasserts req in the same cycle as its release SHALL be arbitrated normally (lowest priority after ptr advance).

Reset
REQ-020 Reset assertion SHALL immediately force state=IDLE, ptr=0, gnt_n=16'hFFFF, gnt_id=0, gnt_valid=0, timeout counter=0.
REQ-021 Reset mid-GRANT SHALL abort the grant without a turnaround cycle; the first grant after reset release SHALL search from index 0.
REQ-022 Reset deassertion SHALL take effect synchronously at the next clk edge.

Configuration
REQ-023 Macro RR_ARB16_TIMEOUT_EN SHALL compile in the hold-timeout feature.
REQ-024 Without the macro no counter SHALL exist and a grant SHALL last until req[owner]=0.
REQ-025 With the macro, a 5-bit counter SHALL count GRANT cycles starting at 1 in the first grant cycle.
REQ-026 When the counter reaches TIMEOUT, the FSM SHALL go GRANT->IDLE on that edge regardless of req[owner], and ptr SHALL already point past the owner.
REQ-027 With the macro, output timeout_o (1 bit, one-cycle pulse on the forced-release edge) SHALL be present; without it the port SHALL be absent.

Structure
REQ-028 Package rr_arb16_pkg SHALL hold NREQ=16, IDW=4, the state enum (IDLE, GRANT), and the TIMEOUT default.
REQ-029 Sub-module onehot_n_dec (combinational 4-to-16 active-low decoder with active-low enable) SHALL produce gnt_n from gnt_id and ~gnt_valid.

Verification
REQ-030 Reset then req=16'h0001 with en_n=0 -> gnt_n=16'hFFFE, gnt_id=0 one cycle later; after req=0, gnt_n=16'hFFFF on the next edge.
REQ-031 Hold req=16'hFFFF, each owner releasing after 2 cycles -> grants SHALL go to ids 0,1,...,15,0 with one idle cycle between grants.
REQ-032 ptr=15 and req=16'h8001 -> grant to 15, then grant to 0 (wrap).
REQ-033 Owner 3 granted, en_n raised -> grant to 3 SHALL persist until req[3]=0, then no grant until en_n=0.
REQ-034 Reset pulse mid-grant to id 7 -> outputs SHALL be idle immediately (asynchronously), and the next grant with req=16'h0081 SHALL go to 0.
REQ-035 With RR_ARB16_TIMEOUT_EN and TIMEOUT=16, req[5] held high -> gnt_valid high for exactly 16 cycles, timeout_o pulses, then the grant goes to another pending requester before returning to 5.
